// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB encodings and the SRAM slave FSM state type.
// size_mask() turns a transfer size and the low address bits into byte lanes.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    // Lanes for up to a 64-bit bus; narrower buses truncate the result.
    function automatic logic [7:0] size_mask(input logic [2:0] hsize,
                                             input logic [2:0] addr_lsb);
        logic [7:0] base;
        case (hsize_t'(hsize))
            HSIZE_BYTE: base = 8'h01;
            HSIZE_HALF: base = 8'h03;
            HSIZE_WORD: base = 8'h0F;
            default:    base = 8'hFF;
        endcase
        return base << addr_lsb;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM with a combinational read port and a
// byte-lane-enabled synchronous write port.
module ahb_sram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned IDX_W      = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                    clk_i,
    input  logic [IDX_W-1:0]        rd_idx_i,
    output logic [DATA_WIDTH-1:0]   rd_data_o,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [DATA_WIDTH/8-1:0] wr_be_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    assign rd_data_o = mem_q[rd_idx_i];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB slave fronting an on-chip SRAM: address-phase capture and error
// classification, programmable wait states and the two-cycle ERROR response.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                    Hclk,
    input  logic                    Hreset,
    input  logic                    Hsel,
    input  logic [ADDR_WIDTH-1:0]   Haddr,
    input  logic                    HWrite,
    input  logic [2:0]              Hsize,
    input  logic [1:0]              Htrans,
    input  logic [DATA_WIDTH/8-1:0] Hstrb,
    input  logic [DATA_WIDTH-1:0]   HWdata,
    input  logic                    Hready,
    output logic                    HreadyOut,
    output logic [1:0]              Hresp,
    output logic [DATA_WIDTH-1:0]   HRdata
);

    localparam int unsigned STRB_W    = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB  = $clog2(STRB_W);
    localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]  MAX_SIZE  = 3'(ADDR_LSB);
    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_STATES);

    state_t                state_q;
    logic [2:0]            wait_cnt_q;
    logic                  hready_q;
    hresp_t                hresp_q;
    logic                  write_q;
    logic [2:0]            hsize_q;
    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_LSB-1:0]   lsb_q;

    logic                  accept;
    logic                  size_err;
    logic                  align_err;
    logic                  range_err;
    logic                  xfer_err;
    logic [ADDR_WIDTH-1:0] word_addr;

    logic                  mem_we;
    logic [STRB_W-1:0]     mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;

    always_comb begin
        accept    = Hsel && Hready &&
                    (htrans_t'(Htrans) == HTRANS_NONSEQ || htrans_t'(Htrans) == HTRANS_SEQ);
        word_addr = Haddr >> ADDR_LSB;
        size_err  = Hsize > MAX_SIZE;
        align_err = (Haddr & ((ADDR_WIDTH'(1) << Hsize) - ADDR_WIDTH'(1))) != '0;
        range_err = word_addr >= ADDR_WIDTH'(MEM_DEPTH);
        xfer_err  = size_err || align_err || range_err;
    end

    // Outputs are registered alongside the state so the asynchronous reset
    // drops HreadyOut/Hresp to ready/OKAY immediately.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            hready_q   <= 1'b1;
            hresp_q    <= HRESP_OKAY;
            write_q    <= 1'b0;
            hsize_q    <= '0;
            idx_q      <= '0;
            lsb_q      <= '0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (wait_cnt_q <= 3'd1) begin
                        state_q    <= S_DATA;
                        wait_cnt_q <= '0;
                        hready_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                S_ERR1: begin
                    state_q  <= S_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    // S_IDLE, S_DATA and S_ERR2 all accept the next transfer.
                    state_q  <= S_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    if (accept) begin
                        write_q <= HWrite;
                        hsize_q <= Hsize;
                        idx_q   <= word_addr[IDX_W-1:0];
                        lsb_q   <= Haddr[ADDR_LSB-1:0];
                        if (xfer_err) begin
                            state_q  <= S_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= S_DATA;
                        end else begin
                            state_q    <= S_WAIT;
                            wait_cnt_q <= WAIT_INIT;
                            hready_q   <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_we = (state_q == S_DATA) && write_q;
        mem_be = Hstrb & STRB_W'(size_mask(hsize_q, 3'(lsb_q)));
        HRdata = ((state_q == S_DATA) && !write_q) ? mem_rdata : '0;
    end

    assign HreadyOut = hready_q;
    assign Hresp     = hresp_q;

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk_i     (Hclk),
        .rd_idx_i  (idx_q),
        .rd_data_o (mem_rdata),
        .wr_en_i   (mem_we),
        .wr_idx_i  (idx_q),
        .wr_be_i   (mem_be),
        .wr_data_i (HWdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two slaves (1 and 0 wait states) on one shared bus,
// a pipelined transfer driver and a reference memory model feeding a scoreboard.
module tb_ahb_sram_slave;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS1   = 1;
    localparam int unsigned WS0   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } tx_t;

    typedef struct {
        logic        err;
        logic        wr;
        logic [31:0] rdata;
        int unsigned waits;
    } exp_t;

    logic        Hclk   = 1'b0;
    logic        Hreset = 1'b0;
    logic        sel    = 1'b0;
    logic        use0   = 1'b0;
    logic [31:0] Haddr  = '0;
    logic        HWrite = 1'b0;
    logic [2:0]  Hsize  = '0;
    logic [1:0]  Htrans = '0;
    logic [3:0]  Hstrb  = '0;
    logic [31:0] HWdata = '0;

    logic        Hsel1, Hsel0, Hready;
    logic        rdy1, rdy0;
    logic [1:0]  resp1, resp0, bus_resp;
    logic [31:0] rd1, rd0, bus_rdata;

    assign Hsel1     = sel && !use0;
    assign Hsel0     = sel && use0;
    assign Hready    = use0 ? rdy0 : rdy1;
    assign bus_resp  = use0 ? resp0 : resp1;
    assign bus_rdata = use0 ? rd0 : rd1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [31:0] model [int];
    tx_t         txq [$];
    exp_t        sb [$];

    always #5 Hclk = ~Hclk;

    ahb_sram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS1)
    ) u_dut1 (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hsel      (Hsel1),
        .Haddr     (Haddr),
        .HWrite    (HWrite),
        .Hsize     (Hsize),
        .Htrans    (Htrans),
        .Hstrb     (Hstrb),
        .HWdata    (HWdata),
        .Hready    (Hready),
        .HreadyOut (rdy1),
        .Hresp     (resp1),
        .HRdata    (rd1)
    );

    ahb_sram_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_DEPTH   (DEPTH),
        .WAIT_STATES (WS0)
    ) u_dut0 (
        .Hclk      (Hclk),
        .Hreset    (Hreset),
        .Hsel      (Hsel0),
        .Haddr     (Haddr),
        .HWrite    (HWrite),
        .Hsize     (Hsize),
        .Htrans    (Htrans),
        .Hstrb     (Hstrb),
        .HWdata    (HWdata),
        .Hready    (Hready),
        .HreadyOut (rdy0),
        .Hresp     (resp0),
        .HRdata    (rd0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [2:0] s,
                       input logic [31:0] d, input logic [3:0] st);
        tx_t t;
        t.addr = a; t.wr = w; t.size = s; t.wdata = d; t.strb = st;
        txq.push_back(t);
    endtask

    // Reference model: a write touches lane b only if strobed and inside
    // [addr%4, addr%4 + 2^size).
    task automatic predict(input tx_t t, output exp_t e);
        int          key;
        logic [31:0] w;
        int unsigned lo, hi;
        e.wr    = t.wr;
        e.rdata = '0;
        e.err   = (t.size > 3'd2) || ((t.addr % (32'd1 << t.size)) != 0) || ((t.addr / 4) >= DEPTH);
        e.waits = e.err ? 1 : (use0 ? WS0 : WS1);
        if (!e.err) begin
            key = int'(use0) * 65536 + int'(t.addr / 4);
            if (t.wr) begin
                w  = model.exists(key) ? model[key] : 32'hxxxxxxxx;
                lo = t.addr % 4;
                hi = lo + (1 << t.size);
                for (int unsigned b = 0; b < 4; b++) begin
                    if (t.strb[b] && b >= lo && b < hi) w[b*8 +: 8] = t.wdata[b*8 +: 8];
                end
                model[key] = w;
            end else begin
                e.rdata = model.exists(key) ? model[key] : 32'hxxxxxxxx;
            end
        end
    endtask

    task automatic run();
        tx_t         a, d;
        exp_t        e;
        bit          a_v = 0;
        bit          d_v = 0;
        logic        rdy;
        int unsigned waits = 0;
        forever begin
            if (!a_v && txq.size() != 0) begin
                a = txq.pop_front();
                a_v = 1;
                predict(a, e);
                sb.push_back(e);
                sel = 1'b1; Htrans = 2'b10; Haddr = a.addr; HWrite = a.wr; Hsize = a.size;
            end else if (!a_v) begin
                sel = 1'b0; Htrans = 2'b00;
            end
            if (!a_v && !d_v) break;
            rdy = Hready;
            if (d_v) begin
                if (!rdy) begin
                    waits++;
                    check("wait_resp", bus_resp, sb[0].err ? 2'b01 : 2'b00);
                    check("wait_rdata", bus_rdata, 32'h0);
                    if (waits > 16) begin
                        check("timeout_waits", waits, sb[0].waits);
                        sb.delete();
                        txq.delete();
                        sel = 1'b0; Htrans = 2'b00;
                        break;
                    end
                end else begin
                    e = sb.pop_front();
                    check("done_waits", waits, e.waits);
                    check("done_resp", bus_resp, e.err ? 2'b01 : 2'b00);
                    check("done_rdata", bus_rdata, (e.wr || e.err) ? 32'h0 : e.rdata);
                end
            end
            @(posedge Hclk); #1;
            if (rdy) begin
                d_v   = a_v;
                d     = a;
                a_v   = 0;
                waits = 0;
                HWdata = (d_v && d.wr) ? d.wdata : 32'h0;
                Hstrb  = (d_v && d.wr) ? d.strb : 4'h0;
            end
        end
    endtask

    initial begin
        #1 Hreset = 1'b1;
        #1;
        check("rst_ready1", rdy1, 1'b1);
        check("rst_resp1", resp1, 2'b00);
        check("rst_rdata1", rd1, 32'h0);
        check("rst_ready0", rdy0, 1'b1);
        check("rst_resp0", resp0, 2'b00);
        check("rst_rdata0", rd0, 32'h0);
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(posedge Hclk); #1;

        use0 = 1'b0;
        add(32'h10, 1, 3'd2, 32'hDEADBEEF, 4'hF);
        add(32'h10, 0, 3'd2, 32'h0, 4'h0);
        add(32'h12, 1, 3'd0, 32'h00AA0000, 4'hF);
        add(32'h10, 0, 3'd2, 32'h0, 4'h0);
        add(32'h13, 1, 3'd1, 32'h12345678, 4'hF);
        add(32'h10, 0, 3'd2, 32'h0, 4'h0);
        add(DEPTH * 4, 1, 3'd2, 32'h55555555, 4'hF);
        add(DEPTH * 4, 0, 3'd2, 32'h0, 4'h0);
        add(32'h14, 1, 3'd2, 32'h11223344, 4'hF);
        add(32'h16, 1, 3'd1, 32'hCAFE0000, 4'hC);
        add(32'h14, 0, 3'd2, 32'h0, 4'h0);
        add(32'h14, 1, 3'd3, 32'hFFFFFFFF, 4'hF);
        add(32'h14, 0, 3'd2, 32'h0, 4'h0);
        add(32'h30, 1, 3'd2, 32'h0, 4'hF);
        run();

        sel = 1'b1; Htrans = 2'b00; HWrite = 1'b1; Haddr = 32'h10; Hsize = 3'd2;
        HWdata = 32'hFFFFFFFF; Hstrb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            @(posedge Hclk); #1;
            check("idle_ready", rdy1, 1'b1);
            check("idle_resp", resp1, 2'b00);
        end
        Htrans = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(posedge Hclk); #1;
            check("busy_ready", rdy1, 1'b1);
            check("busy_resp", resp1, 2'b00);
        end
        sel = 1'b0; Htrans = 2'b00;
        add(32'h10, 0, 3'd2, 32'h0, 4'h0);
        run();

        sel = 1'b1; Htrans = 2'b10; Haddr = 32'h30; HWrite = 1'b1; Hsize = 3'd2;
        @(posedge Hclk); #1;
        sel = 1'b0; Htrans = 2'b00; HWdata = 32'hFFFFFFFF; Hstrb = 4'hF;
        check("mid_wait_ready", rdy1, 1'b0);
        Hreset = 1'b1;
        #1;
        check("mid_rst_ready", rdy1, 1'b1);
        check("mid_rst_resp", resp1, 2'b00);
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        @(posedge Hclk); #1;
        add(32'h30, 0, 3'd2, 32'h0, 4'h0);
        run();

        use0 = 1'b1;
        add(32'h20, 1, 3'd2, 32'h12345678, 4'hF);
        add(32'h20, 0, 3'd2, 32'h0, 4'h0);
        add(32'h24, 1, 3'd2, 32'h0, 4'hF);
        add(32'h24, 1, 3'd2, 32'hFFFFFFFF, 4'h3);
        add(32'h24, 0, 3'd2, 32'h0, 4'h0);
        add(32'h21, 0, 3'd0, 32'h0, 4'h0);
        add(32'h22, 0, 3'd1, 32'h0, 4'h0);
        add(DEPTH * 4, 0, 3'd2, 32'h0, 4'h0);
        add(32'h20, 0, 3'd2, 32'h0, 4'h0);
        run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB slave that receives the transfers driven by ahb_master (via the bus decoder and mux) and completes them against an on-chip word-organised SRAM.
- Implements the pipelined address/data phases, a programmable number of wait states and a two-cycle ERROR response.
- Provides the data-phase partner for the master FSM: it drives HreadyOut, Hresp and HRdata, which return to the master as Hready, Hresp and HRdata.

Parameters:
- ADDR_WIDTH, 32, width of Haddr.
- DATA_WIDTH, 32, width of the data buses; must be 32 or 64.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words in the SRAM.
- WAIT_STATES, 1, extra data-phase cycles per OKAY transfer, legal range 0..7.

Ports:
- Hclk  in  1  bus clock; all state is on the rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Hsel  in  1  slave select from the address decoder.
- Haddr  in  ADDR_WIDTH  address-phase byte address.
- HWrite  in  1  1 = write, 0 = read.
- Hsize  in  3  transfer size, log2 of bytes.
- Htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- Hstrb  in  DATA_WIDTH/8  write byte strobes, data phase.
- HWdata  in  DATA_WIDTH  write data, data phase.
- Hready  in  1  bus-level ready (previous transfer complete).
- HreadyOut  out  1  this slave's ready.
- Hresp  out  2  00 OKAY, 01 ERROR.
- HRdata  out  DATA_WIDTH  read data.

Behaviour:
- Clock and reset: one clock (Hclk); reset Hreset is asynchronous and active-high.
- Reset values: HreadyOut=1, Hresp=OKAY, HRdata=0, FSM=S_IDLE, wait counter=0. SRAM contents are not reset.
- Accept condition: a transfer is accepted on the rising edge where Hsel && Hready && Htrans[1]. On that edge, capture Haddr, HWrite and Hsize, and classify the transfer.
- Error classification: the transfer is an error if any of the following holds:
  - Hsize > log2(DATA_WIDTH/8);
  - Haddr is not aligned to 2^Hsize;
  - the word index Haddr >> log2(DATA_WIDTH/8) is >= MEM_DEPTH.
- IDLE/BUSY, or Hsel=0: no access. FSM goes to or stays in S_IDLE, with HreadyOut=1 and Hresp=OKAY.
- FSM states:
  - S_IDLE: HreadyOut=1, Hresp=OKAY. On accept, go to S_ERR1 if the transfer is an error. Otherwise go to S_WAIT with counter=WAIT_STATES, or to S_DATA if WAIT_STATES=0.
  - S_WAIT: HreadyOut=0, Hresp=OKAY. Decrement the counter each cycle; go to S_DATA when the counter reaches 1.
  - S_DATA: HreadyOut=1, Hresp=OKAY; this is the completing cycle.
    - Read: HRdata = mem[word] combinationally in this cycle.
    - Write: on the exiting edge, write HWdata to lanes where Hstrb & size_mask is set. size_mask is derived from Hsize and the low address bits.
    - The same edge may accept the next transfer (pipelining), with the same transitions as S_IDLE; otherwise go to S_IDLE.
  - S_ERR1: HreadyOut=0, Hresp=ERROR. Always go to S_ERR2.
  - S_ERR2: HreadyOut=1, Hresp=ERROR. No memory access. May accept a new transfer like S_DATA.
- Latency: an OKAY transfer completes WAIT_STATES+1 cycles after its address phase. An error completes after 2 cycles.
- Read-after-write to the same word, back to back: the write lands on the edge ending its S_DATA, so the following read's data phase returns the new data. No forwarding is required.
- HRdata outside the S_DATA read cycle: hold 0.
- Hreset asserted mid-transfer: immediately HreadyOut=1 and Hresp=OKAY; any pending write is dropped (memory unchanged).

Decomposition:
- Package ahb_pkg holds:
  - htrans_t (IDLE/BUSY/NONSEQ/SEQ);
  - hresp_t (OKAY/ERROR/RETRY/SPLIT);
  - hsize_t encodings;
  - the slave FSM enum state_t (S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2);
  - function size_mask(hsize, addr_lsb).
- Sub-module ahb_sram_mem is the byte-lane-enabled array, with a combinational read port and a synchronous write port taking a word index, a byte-enable vector and data.
- Top level: FSM, address/control capture and error classification.

Test Plan:
- Write then read, WAIT_STATES=1, DATA_WIDTH=32:
  - NONSEQ write Haddr=0x10, word, HWdata=0xDEADBEEF, Hstrb=0xF -> HreadyOut low for exactly 1 cycle, then high with OKAY;
  - read 0x10 -> HRdata=0xDEADBEEF in the completing cycle.
- Byte write, with 0x10 holding 0xDEADBEEF:
  - Haddr=0x12, Hsize=0, HWdata=0x00AA0000, Hstrb=0xF -> word 0x10 reads 0xDEAABEEF (only lane 2 written).
- Unaligned halfword write to Haddr=0x13:
  - cycle 1: HreadyOut=0, Hresp=01;
  - cycle 2: HreadyOut=1, Hresp=01;
  - memory unchanged.
- Back-to-back pipelined, WAIT_STATES=0:
  - write 0x20=0x12345678, immediately followed by read 0x20 -> read completes the next cycle with HRdata=0x12345678 and no stall.
- Out of range and IDLE:
  - Haddr=MEM_DEPTH*4 -> ERROR two-cycle response;
  - Htrans=IDLE with Hsel=1 -> HreadyOut stays 1, Hresp=OKAY, no write.
- Reset mid-transfer:
  - assert Hreset during S_WAIT of a write to 0x30 (old value 0x0) -> HreadyOut=1 and Hresp=OKAY without waiting for a clock edge;
  - after release, a read of 0x30 returns 0x0.
